// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU load/store execute stage.
package mmu_pkg;

    localparam int REG_AW = 4;
    localparam int SLOT_W = 4;
    localparam int LOC_W  = 4;
    localparam int MEM_AW = SLOT_W + LOC_W;
    localparam int CTR_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RDREG,
        ST_MEMWAIT,
        ST_WB,
        ST_FIN
    } state_t;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE     = 2'b00;
    localparam err_code_t ERR_INVALID  = 2'b01;
    localparam err_code_t ERR_CONFLICT = 2'b10;
    localparam err_code_t ERR_TIMEOUT  = 2'b11;

    // Classifies a decoded command; ERR_NONE means exactly one of ld/st is set.
    function automatic err_code_t decode_err(input logic ld, input logic st);
        if (ld && st)
            return ERR_CONFLICT;
        else if (!ld && !st)
            return ERR_INVALID;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/mmu_timeout_ctr.sv
// Clearable, saturating 8-bit wait counter; terminal marks the LIMIT-th counted cycle.
module mmu_timeout_ctr
    import mmu_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic terminal
);

    localparam logic [CTR_W-1:0] LAST = CTR_W'(LIMIT - 1);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

    // count holds the cycles already waited, so count == LIMIT-1 means this is the last one.
    assign terminal = (count == LAST);

endmodule

// File: rtl/mmu_ls_exec.sv
// Load/store execute stage: moves one word between the register file and memory per command.
module mmu_ls_exec
    import mmu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_ld,
    input  logic                cmd_st,
    input  logic [REG_AW-1:0]   cmd_reg_addr,
    input  logic [LOC_W-1:0]    cmd_mem_addr,
    input  logic [SLOT_W-1:0]   cmd_sl_select,
    output logic [REG_AW-1:0]   rf_raddr,
    input  logic [DATA_W-1:0]   rf_rdata,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);

    state_t    state;
    logic      is_ld_q;
    err_code_t accept_code;
    logic      ctr_clr;
    logic      ctr_inc;
    logic      ctr_terminal;

    assign accept_code = decode_err(cmd_ld, cmd_st);

    // The counter is cleared on every transition into MEMWAIT.
    assign ctr_clr = ((state == ST_IDLE) && cmd_valid && (accept_code == ERR_NONE) && cmd_ld)
                   || (state == ST_RDREG);
    assign ctr_inc = (state == ST_MEMWAIT) && !mem_ack;

    mmu_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .inc      (ctr_inc),
        .terminal (ctr_terminal)
    );

    // NOTE: all state and outputs are registered with non-blocking assignments so every
    // branch below reads the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            is_ld_q   <= 1'b0;
            cmd_ready <= 1'b1;
            rf_raddr  <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rf_we <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        is_ld_q  <= cmd_ld;
                        rf_raddr <= cmd_reg_addr;
                        mem_addr <= {cmd_sl_select, cmd_mem_addr};
                        if (accept_code != ERR_NONE) begin
                            err      <= 1'b1;
                            err_code <= accept_code;
                        end else if (cmd_st) begin
                            state     <= ST_RDREG;
                            cmd_ready <= 1'b0;
                        end else begin
                            state     <= ST_MEMWAIT;
                            cmd_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                        end
                    end
                end

                ST_RDREG: begin
                    mem_wdata <= rf_rdata;
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    state     <= ST_MEMWAIT;
                end

                ST_MEMWAIT: begin
                    // An ack on the terminal cycle still completes the command.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (is_ld_q) begin
                            rf_we    <= 1'b1;
                            rf_waddr <= rf_raddr;
                            rf_wdata <= mem_rdata;
                            state    <= ST_WB;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end
                    end else if (ctr_terminal) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        err       <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                ST_WB: begin
                    done  <= 1'b1;
                    state <= ST_FIN;
                end

                ST_FIN: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_ls_exec.sv
// Scoreboard bench for mmu_ls_exec: expected events are queued at stimulus time, compared on output.
module tb_mmu_ls_exec;
    import mmu_pkg::*;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    typedef struct packed { logic we; logic [7:0] addr; logic [DATA_W-1:0] wdata; } mem_ev_t;
    typedef struct packed { logic [3:0] waddr; logic [DATA_W-1:0] wdata; } rf_ev_t;
    typedef struct packed { logic done; logic err; logic [1:0] code; } end_ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_ld = 1'b0, cmd_st = 1'b0;
    logic [3:0]        cmd_reg_addr = '0, cmd_mem_addr = '0, cmd_sl_select = '0;
    logic [3:0]        rf_raddr, rf_waddr;
    logic [DATA_W-1:0] rf_rdata, rf_wdata, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              rf_we, mem_req, mem_we, done, err;
    logic              mem_ack = 1'b0;
    logic [7:0]        mem_addr;
    logic [1:0]        err_code;

    logic [DATA_W-1:0] rf_model [16];
    assign rf_rdata = rf_model[rf_raddr];

    mem_ev_t exp_mem[$], obs_mem[$];
    rf_ev_t  exp_rf[$],  obs_rf[$];
    end_ev_t exp_end[$], obs_end[$];

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] last_code = ERR_NONE;

    always #5 clk = ~clk;

    mmu_ls_exec #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_st(cmd_st),
        .cmd_reg_addr(cmd_reg_addr), .cmd_mem_addr(cmd_mem_addr), .cmd_sl_select(cmd_sl_select),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .err(err), .err_code(err_code)
    );

    // Called at a falling edge; returns at the falling edge of the first cycle after accept.
    task automatic issue(input logic ld, input logic st, input logic [3:0] ra,
                         input logic [3:0] sl, input logic [3:0] loc);
        cmd_valid = 1'b1; cmd_ld = ld; cmd_st = st;
        cmd_reg_addr = ra; cmd_sl_select = sl; cmd_mem_addr = loc;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_st = 1'b0;
    endtask

    // Records DUT events cycle by cycle and acks the ack_delay-th request cycle (-1: never).
    task automatic observe(input int budget, input int ack_delay,
                           output int end_lat, output int req_cycles);
        int   waited;
        logic prev_req;
        waited = 0; prev_req = 1'b0; end_lat = -1; req_cycles = 0;
        obs_mem.delete(); obs_rf.delete(); obs_end.delete();
        for (int lat = 1; lat <= budget; lat++) begin
            if (mem_req && !prev_req) obs_mem.push_back({mem_we, mem_addr, mem_wdata});
            if (rf_we) obs_rf.push_back({rf_waddr, rf_wdata});
            if (done || err) obs_end.push_back({done, err, err_code});
            prev_req = mem_req;
            if (done || err) begin
                end_lat = lat;
                break;
            end
            if (mem_req) begin
                req_cycles++;
                mem_ack = (waited == ack_delay);
                waited++;
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
        checks++;
        if ({mem_req, mem_we, rf_we, done, err, err_code} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got req=%b we=%b rf_we=%b done=%b err=%b code=%b want all 0",
                     mem_req, mem_we, rf_we, done, err, err_code);
        end
        checks++;
        if ({rf_raddr, rf_waddr, rf_wdata, mem_addr, mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: got raddr=%h waddr=%h wdata=%h addr=%h mwdata=%h want 0",
                     rf_raddr, rf_waddr, rf_wdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, mem_req, done, err} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_idle: got ready=%b req=%b done=%b err=%b want 1000",
                     cmd_ready, mem_req, done, err);
        end
    endtask

    task automatic test_store();
        int lat, reqc;
        mem_ev_t em, om;
        end_ev_t ee, oe;
        rf_model[3] = 32'hDEADBEEF;
        exp_mem.push_back({1'b1, 8'h25, 32'hDEADBEEF});
        exp_end.push_back({1'b1, 1'b0, last_code});
        @(negedge clk);
        issue(1'b0, 1'b1, 4'd3, 4'd2, 4'd5);
        observe(20, 2, lat, reqc);
        checks++;
        if (lat != 5) begin failures++; $display("FAIL store_latency: got %0d want 5", lat); end
        em = exp_mem.pop_front();
        om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
        checks++;
        if (om !== em) begin
            failures++;
            $display("FAIL store_mem: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                     om.we, om.addr, om.wdata, em.we, em.addr, em.wdata);
        end
        ee = exp_end.pop_front();
        oe = (obs_end.size() > 0) ? obs_end.pop_front() : '0;
        checks++;
        if (oe !== ee) begin failures++; $display("FAIL store_end: got %b want %b", oe, ee); end
        checks++;
        if (obs_rf.size() != 0) begin
            failures++; $display("FAIL store_no_rf_we: got %0d writes want 0", obs_rf.size());
        end
    endtask

    task automatic test_load();
        int lat, reqc;
        mem_ev_t em, om;
        rf_ev_t  er, orr;
        end_ev_t ee, oe;
        mem_rdata = 32'h12345678;
        exp_mem.push_back({1'b0, 8'hF0, 32'h0});
        exp_rf.push_back({4'd7, 32'h12345678});
        exp_end.push_back({1'b1, 1'b0, last_code});
        @(negedge clk);
        issue(1'b1, 1'b0, 4'd7, 4'hF, 4'h0);
        observe(20, 0, lat, reqc);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL load_latency: got %0d want 3", lat); end
        em = exp_mem.pop_front();
        om = (obs_mem.size() > 0) ? obs_mem.pop_front() : {1'b1, 8'h00, 32'h0};
        checks++;
        if ({om.we, om.addr} !== {em.we, em.addr}) begin
            failures++;
            $display("FAIL load_mem: got we=%b addr=%h want we=%b addr=%h", om.we, om.addr, em.we, em.addr);
        end
        er = exp_rf.pop_front();
        orr = (obs_rf.size() > 0) ? obs_rf.pop_front() : '0;
        checks++;
        if (orr !== er) begin
            failures++;
            $display("FAIL load_rf: got waddr=%h wdata=%h want waddr=%h wdata=%h",
                     orr.waddr, orr.wdata, er.waddr, er.wdata);
        end
        checks++;
        if (obs_rf.size() != 0) begin
            failures++; $display("FAIL load_single_rf_we: got %0d extra writes want 0", obs_rf.size());
        end
        ee = exp_end.pop_front();
        oe = (obs_end.size() > 0) ? obs_end.pop_front() : '0;
        checks++;
        if (oe !== ee) begin failures++; $display("FAIL load_end: got %b want %b", oe, ee); end
    endtask

    task automatic test_invalid_conflict();
        end_ev_t ee, oe;
        logic    saw_req, ready_low;
        saw_req = 1'b0; ready_low = 1'b0;
        obs_end.delete();
        exp_end.push_back({1'b0, 1'b1, ERR_INVALID});
        exp_end.push_back({1'b0, 1'b1, ERR_CONFLICT});
        @(negedge clk);
        cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_st = 1'b0;
        cmd_reg_addr = 4'd1; cmd_sl_select = 4'd1; cmd_mem_addr = 4'd1;
        @(posedge clk);
        @(negedge clk);
        if (err) obs_end.push_back({done, err, err_code});
        saw_req |= mem_req; ready_low |= !cmd_ready;
        cmd_ld = 1'b1; cmd_st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (err) obs_end.push_back({done, err, err_code});
        saw_req |= mem_req; ready_low |= !cmd_ready;
        cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_st = 1'b0;
        @(negedge clk);
        saw_req |= mem_req; ready_low |= !cmd_ready;
        for (int i = 0; i < 2; i++) begin
            ee = exp_end.pop_front();
            oe = (obs_end.size() > 0) ? obs_end.pop_front() : '0;
            checks++;
            if (oe !== ee) begin failures++; $display("FAIL invalid_err_%0d: got %b want %b", i, oe, ee); end
        end
        checks++;
        if (saw_req !== 1'b0) begin failures++; $display("FAIL invalid_no_req: got mem_req=1 want 0"); end
        checks++;
        if (ready_low !== 1'b0) begin failures++; $display("FAIL invalid_ready: got cmd_ready=0 want 1"); end
        checks++;
        if ({err, err_code} !== {1'b0, ERR_CONFLICT}) begin
            failures++; $display("FAIL invalid_pulse: got err=%b code=%b want err=0 code=10", err, err_code);
        end
        last_code = ERR_CONFLICT;
    endtask

    task automatic test_timeout();
        int lat, reqc;
        end_ev_t ee, oe;
        exp_end.push_back({1'b0, 1'b1, ERR_TIMEOUT});
        @(negedge clk);
        issue(1'b1, 1'b0, 4'd2, 4'hA, 4'h3);
        observe(20, -1, lat, reqc);
        checks++;
        if (reqc != TIMEOUT) begin failures++; $display("FAIL timeout_req_cycles: got %0d want %0d", reqc, TIMEOUT); end
        checks++;
        if (lat != TIMEOUT + 1) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", lat, TIMEOUT + 1); end
        ee = exp_end.pop_front();
        oe = (obs_end.size() > 0) ? obs_end.pop_front() : '0;
        checks++;
        if (oe !== ee) begin failures++; $display("FAIL timeout_end: got %b want %b", oe, ee); end
        checks++;
        if (obs_rf.size() != 0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL timeout_idle: got rf_writes=%0d ready=%b want 0 and 1", obs_rf.size(), cmd_ready);
        end
        last_code = ERR_TIMEOUT;
    endtask

    task automatic test_ack_at_limit();
        int lat, reqc;
        rf_ev_t  er, orr;
        end_ev_t ee, oe;
        mem_rdata = 32'hCAFEF00D;
        exp_rf.push_back({4'd1, 32'hCAFEF00D});
        exp_end.push_back({1'b1, 1'b0, last_code});
        @(negedge clk);
        issue(1'b1, 1'b0, 4'd1, 4'h6, 4'h9);
        observe(20, TIMEOUT - 1, lat, reqc);
        checks++;
        if (lat != TIMEOUT + 2) begin failures++; $display("FAIL limit_latency: got %0d want %0d", lat, TIMEOUT + 2); end
        ee = exp_end.pop_front();
        oe = (obs_end.size() > 0) ? obs_end.pop_front() : '0;
        checks++;
        if (oe !== ee) begin failures++; $display("FAIL limit_end: got %b want %b", oe, ee); end
        er = exp_rf.pop_front();
        orr = (obs_rf.size() > 0) ? obs_rf.pop_front() : '0;
        checks++;
        if (orr !== er) begin
            failures++; $display("FAIL limit_rf: got %h/%h want %h/%h", orr.waddr, orr.wdata, er.waddr, er.wdata);
        end
    endtask

    task automatic test_reset_midop();
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        issue(1'b1, 1'b0, 4'd9, 4'h1, 4'h1);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin failures++; $display("FAIL midop_in_wait: got mem_req=%b want 1", mem_req); end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, rf_we, cmd_ready} !== 3'b001) begin
            failures++; $display("FAIL midop_async: got req=%b rf_we=%b ready=%b want 0 0 1", mem_req, rf_we, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        last_code = ERR_NONE;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bad |= mem_req | rf_we | done | err | !cmd_ready;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL midop_stale_ack: got activity=1 want 0"); end
        checks++;
        if (err_code !== ERR_NONE) begin failures++; $display("FAIL midop_code: got %b want 00", err_code); end
    endtask

    task automatic test_back_to_back();
        int lat, reqc, dly;
        logic ld;
        logic [3:0] ra, sl, loc;
        logic [DATA_W-1:0] data;
        mem_ev_t em, om;
        rf_ev_t  er, orr;
        end_ev_t ee, oe;
        for (int i = 0; i < 6; i++) begin
            ld   = i[0];
            ra   = 4'($urandom_range(0, 15));
            sl   = 4'($urandom_range(0, 15));
            loc  = 4'($urandom_range(0, 15));
            dly  = $urandom_range(0, TIMEOUT - 1);
            data = $urandom;
            if (ld) begin
                mem_rdata = data;
                exp_rf.push_back({ra, data});
            end else begin
                rf_model[ra] = data;
            end
            exp_mem.push_back({!ld, sl, loc, ld ? 32'h0 : data});
            exp_end.push_back({1'b1, 1'b0, last_code});
            @(negedge clk);
            issue(ld, !ld, ra, sl, loc);
            observe(20, dly, lat, reqc);
            checks++;
            if (lat != 3 + dly) begin failures++; $display("FAIL b2b_%0d_latency: got %0d want %0d", i, lat, 3 + dly); end
            em = exp_mem.pop_front();
            om = (obs_mem.size() > 0) ? obs_mem.pop_front() : '0;
            if (ld) om.wdata = '0;
            checks++;
            if (om !== em) begin
                failures++;
                $display("FAIL b2b_%0d_mem: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                         i, om.we, om.addr, om.wdata, em.we, em.addr, em.wdata);
            end
            ee = exp_end.pop_front();
            oe = (obs_end.size() > 0) ? obs_end.pop_front() : '0;
            checks++;
            if (oe !== ee) begin failures++; $display("FAIL b2b_%0d_end: got %b want %b", i, oe, ee); end
            if (ld) begin
                er = exp_rf.pop_front();
                orr = (obs_rf.size() > 0) ? obs_rf.pop_front() : '0;
                checks++;
                if (orr !== er) begin
                    failures++; $display("FAIL b2b_%0d_rf: got %h/%h want %h/%h", i, orr.waddr, orr.wdata, er.waddr, er.wdata);
                end
            end else begin
                checks++;
                if (obs_rf.size() != 0) begin failures++; $display("FAIL b2b_%0d_no_rf_we: got %0d writes", i, obs_rf.size()); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_model[i] = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_store();
        test_load();
        test_invalid_conflict();
        test_timeout();
        test_ack_at_limit();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmu_ls_exec.md
Name: mmu_ls_exec

Overview:
- Execute stage directly downstream of the MMU instruction decoder.
- Accepts one decoded load/store command per handshake and moves one word between the 16-entry register file and local memory.
  - Load: memory to register.
  - Store: register to memory.
- Sequences the register-file ports and a req/ack memory port, enforces a memory timeout, and reports done/error to the control path.

Parameters:
- DATA_W, 32, width of register and memory words.
- TIMEOUT, 15, max cycles waiting for mem_ack before abort; must be 1..255.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  decoded command present.
- cmd_ready  out  1  block can accept a command.
- cmd_ld  in  1  load request.
- cmd_st  in  1  store request.
- cmd_reg_addr  in  4  register index.
- cmd_mem_addr  in  4  memory location within slot.
- cmd_sl_select  in  4  slot select (upper memory address bits).
- rf_raddr  out  4  register read address.
- rf_rdata  in  DATA_W  register read data, combinational from rf_raddr.
- rf_we  out  1  register write enable.
- rf_waddr  out  4  register write address.
- rf_wdata  out  DATA_W  register write data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write (store), 0 = read (load).
- mem_addr  out  8  {sl_select, mem_addr}.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- done  out  1  one-cycle pulse, command completed successfully.
- err  out  1  one-cycle pulse, command rejected or timed out.
- err_code  out  2  00 none, 01 invalid (neither ld nor st), 10 conflict (ld and st both set), 11 timeout; holds last error code until next err pulse.

Behaviour:
- Reset values:
  - State IDLE.
  - cmd_ready=1.
  - mem_req=0, mem_we=0, rf_we=0, done=0, err=0, err_code=00.
  - Address and data outputs all 0.
  - Timeout counter 0.
- States: IDLE, RDREG, MEMWAIT, WB, FIN.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid & cmd_ready; latch all cmd_* fields.
  - Decision at accept:
    - ld & st: err pulse next cycle, err_code=10, stay IDLE.
    - ~ld & ~st: err pulse, err_code=01, stay IDLE.
    - st only: go RDREG.
    - ld only: go MEMWAIT with mem_req=1, mem_we=0.
- RDREG (store, 1 cycle):
  - rf_raddr=latched reg.
  - Register rf_rdata into mem_wdata at end of cycle.
  - Go MEMWAIT with mem_req=1, mem_we=1.
- MEMWAIT:
  - mem_req, mem_we, mem_addr, mem_wdata held stable until ack.
  - Counter increments each cycle without ack.
  - mem_ack: mem_req drops next cycle.
    - Load: capture mem_rdata, go WB.
    - Store: go FIN.
  - Counter reaches TIMEOUT with no ack: drop mem_req, err pulse, err_code=11, go IDLE.
  - An ack arriving in the same cycle the counter hits TIMEOUT counts as success; ack wins.
- WB (1 cycle): rf_we=1, rf_waddr=latched reg, rf_wdata=captured data; go FIN.
- FIN (1 cycle): done=1; go IDLE.
- cmd_ready is 0 in every state except IDLE. No overlap between commands.
- mem_ack outside MEMWAIT is ignored.
- Latency from accept to done pulse:
  - Load: 3 + (ack wait) cycles.
  - Store: 3 + (ack wait) cycles.
  - Zero-wait ack (ack in first MEMWAIT cycle): done appears 3 cycles after accept.
- The error pulse appears the cycle after accept, and cmd_ready stays 1. Back-to-back invalid commands therefore each produce an err pulse.
- rst asserted mid-operation:
  - Immediate return to reset values.
  - No rf_we issued.
  - mem_req drops asynchronously.
  - The in-flight command is discarded.
- Timeout counter is 8 bits wide and clears on entering MEMWAIT.

Decomposition:
- Shared package mmu_pkg:
  - State enum (IDLE, RDREG, MEMWAIT, WB, FIN).
  - err_code constants (ERR_NONE, ERR_INVALID, ERR_CONFLICT, ERR_TIMEOUT).
  - Address widths REG_AW=4, SLOT_W=4, LOC_W=4.
- One natural sub-module: mmu_timeout_ctr, a clearable, saturating 8-bit counter with terminal flag at TIMEOUT.

Test Plan:
- Store: rf[3]=0xDEADBEEF; cmd st, reg 3, sl 2, mem 5; ack after 2 cycles.
  - Expect mem_req with mem_we=1, mem_addr=0x25, mem_wdata=0xDEADBEEF.
  - Expect done 5 cycles after accept, no rf_we.
- Load: cmd ld, reg 7, sl 0xF, mem 0; mem_rdata=0x12345678 with zero-wait ack.
  - Expect mem_addr=0xF0, mem_we=0.
  - Expect one rf_we with waddr 7, wdata 0x12345678.
  - Expect done 3 cycles after accept.
- Invalid/conflict: cmd with ld=st=0, then ld=st=1 back-to-back.
  - Expect two err pulses with codes 01 then 10, no mem_req, cmd_ready stays 1.
- Timeout: TIMEOUT=4, load with mem_ack never asserted.
  - Expect mem_req high for 4 cycles, then err with code 11, no rf_we, return to IDLE.
- Ack at limit: ack in the same cycle the counter reaches TIMEOUT.
  - Expect done, not err.
- Reset mid-op: assert rst while in MEMWAIT of a load.
  - Expect mem_req=0 immediately, no rf_we, cmd_ready=1 after release.
  - Expect a stale ack after release to be ignored.
